// File: rtl/truth_table_sequencer_if.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer_if
//   Handshake and circuit-side bundle for the truth-table sequencer.
//
//   Signals:
//     start       - begin a sweep (host -> sequencer)
//     abort       - cancel a sweep in progress (host -> sequencer)
//     z_in        - output of the circuit under test (circuit -> sequencer)
//     vec_out     - input vector to the circuit, MSB = input A (sequencer -> circuit)
//     busy        - sweep in progress (sequencer -> host)
//     done        - one-cycle completion pulse (sequencer -> host)
//     table_valid - truth_table holds a complete, unaborted sweep
//     truth_table - bit i = z_in sampled while vec_out == i
//
//   Modports:
//     master - the sequencer itself (drives the circuit inputs and status)
//     slave  - host / circuit side that observes the sequencer
// ---------------------------------------------------------------------------
interface truth_table_sequencer_if #(
    parameter int N_IN = 3
) ();
    logic                 start;
    logic                 abort;
    logic                 z_in;
    logic [N_IN-1:0]      vec_out;
    logic                 busy;
    logic                 done;
    logic                 table_valid;
    logic [(2**N_IN)-1:0] truth_table;

    modport master (
        input  start, abort, z_in,
        output vec_out, busy, done, table_valid, truth_table
    );

    modport slave (
        output start, abort, z_in,
        input  vec_out, busy, done, table_valid, truth_table
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer
//   Drives a combinational circuit with every input combination
//   0 .. 2**N_IN-1, holding each vector for DWELL clocks, and samples the
//   circuit output on the last clock of each dwell to build its truth table.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - truth_table_sequencer_if.master (start/abort/z_in in;
//            vec_out/busy/done/table_valid/truth_table out)
//
//   Parameters:
//     N_IN  - number of circuit inputs (table width 2**N_IN)
//     DWELL - clocks each vector is held, 1..255
//
//   Every output comes straight from a flop; z_in only reaches the table
//   register, so there is no combinational z_in -> output path.
// ---------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int N_IN  = 3,
    parameter int DWELL = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    truth_table_sequencer_if.master       bus
);
    localparam int TBL_W = 2 ** N_IN;

    localparam logic [7:0]      CNT_LAST = 8'(DWELL - 1);
    localparam logic [7:0]      CNT_ONE  = 8'd1;
    localparam logic [N_IN-1:0] VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q,   cnt_d;
    logic [N_IN-1:0]   vec_q,   vec_d;
    logic [TBL_W-1:0]  table_q, table_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            table_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        table_d = table_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                vec_d = '0;
                cnt_d = '0;
                // abort dominates start so a host can hold off a sweep
                if (bus.start && !bus.abort) begin
                    state_d = RUN;
                    table_d = '0;
                    valid_d = 1'b0;
                end
            end

            RUN: begin
                if (bus.abort) begin
                    // partial table is left as-is; table_valid stays low
                    state_d = IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // last clock of this vector's dwell: capture the output
                    table_d[vec_q] = bus.z_in;
                    cnt_d          = '0;
                    // terminal vector is detected explicitly, vec never wraps
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        vec_d   = '0;
                        valid_d = 1'b1;
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DONE: begin
                state_d = IDLE;
                vec_d   = '0;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                vec_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // status flags are registered copies of the upcoming state
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign bus.vec_out     = vec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.table_valid = valid_q;
    assign bus.truth_table = table_q;

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Hardware stimulus-and-capture stage for the 3-input combinational lab circuits.
- Upstream role: sweeps the circuit inputs through every combination 0..2**N_IN-1 and holds each vector for DWELL clocks.
- Downstream role: samples the circuit's single output at the end of each dwell and assembles the full truth table into one register.
- Replaces the hand-written #5 stimulus sequence with a synthesizable sequencer driven by a start/busy/done handshake.

Parameters:
- N_IN, 3, number of circuit inputs driven; table width is 2**N_IN.
- DWELL, 5, clocks each vector is held; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel a sweep in progress.
- z_in  input  1  output of the circuit under test.
- vec_out  output  N_IN  input vector to the circuit; MSB = first input (A), LSB = last input (C).
- busy  output  1  high while a sweep is in progress.
- done  output  1  single-cycle pulse when a sweep completes.
- table_valid  output  1  truth_table holds a complete, unaborted sweep.
- truth_table  output  2**N_IN  bit i = z_in sampled while vec_out == i.

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Reset values: state = IDLE, vec_out = 0, busy = 0, done = 0, table_valid = 0, truth_table = 0, dwell counter = 0. Reset takes effect immediately, including mid-sweep.
- States: IDLE, RUN, DONE.
- IDLE:
  - vec_out = 0, busy = 0.
  - start=1 and abort=0 at edge k: go to RUN; clear truth_table and table_valid; vec_out = 0 and dwell counter = 0 from k+1.
  - start=1 and abort=1 together: abort wins, stay in IDLE, nothing cleared.
- RUN:
  - busy = 1; dwell counter increments each clock.
  - When counter == DWELL-1:
    - truth_table[vec_out] <= z_in.
    - If vec_out == 2**N_IN-1, go to DONE.
    - Otherwise vec_out increments and the counter returns to 0.
  - Each vector is therefore held exactly DWELL clocks and sampled on its last clock.
  - The sweep lasts exactly 2**N_IN*DWELL clocks: for start at edge k, busy is high for edges k+1 .. k+2**N_IN*DWELL.
- DONE:
  - Lasts one clock: done = 1, busy = 0, table_valid <= 1, vec_out returns to 0; then go to IDLE.
  - start during DONE is ignored.
- abort during RUN:
  - Next edge enters IDLE, with vec_out = 0 and counter = 0.
  - done is not pulsed and table_valid stays 0.
  - truth_table keeps its partial contents; they are don't-care.
- start during RUN or DONE is ignored; a sweep is never restarted mid-flight.
- All outputs are registered; no combinational path from z_in to any output.
- DWELL=1: a new vector every clock, each sampled on the same clock it is driven.
- Widths:
  - Dwell counter is 8 bits, compared against DWELL-1.
  - vec_out does not wrap during a sweep; the terminal vector is detected explicitly.
- table_valid and truth_table hold until the next accepted start or rst.

Test Plan:
- Full sweep, DWELL=5, z_in = A&B | C modelled combinationally from vec_out; pulse start → busy high for 40 clocks, vec_out steps 0..7 every 5 clocks, done one pulse, truth_table = 8'hEA, table_valid = 1.
- DWELL=1, z_in = constant 1 → busy exactly 8 clocks, truth_table = 8'hFF, done one clock after the final sample.
- abort asserted at the 13th RUN clock → IDLE next edge, vec_out = 0, no done, table_valid = 0; a new start then completes normally with 8'hEA.
- Extra start pulses mid-sweep and in the DONE cycle → ignored, sweep length still 40 clocks; start+abort together in IDLE → stays IDLE.
- rst asserted asynchronously mid-sweep (between clock edges) → all outputs return to reset values immediately; a following start runs a full sweep.
- z_in = XOR of the vec_out bits (parity), DWELL=5 → truth_table = 8'h96; z_in glitch toggled away from dwell ends does not affect the result.
